// File: rtl/ace_pkg.sv
// ace_pkg: ACE snoop/response encodings and the port FSM and request-kind types
package ace_pkg;
  localparam logic [3:0] ARSNOOP_READSHARED  = 4'b0001;
  localparam logic [3:0] ARSNOOP_CLEANUNIQUE = 4'b1011;
  localparam logic [2:0] AWSNOOP_WRITEBACK   = 3'b011;
  localparam logic [1:0] RESP_OKAY           = 2'b00;
  typedef enum logic [2:0] {IDLE, AR_ADDR, R_DATA, AW_ADDR, W_DATA, B_RESP, ACK} port_state_e;
  typedef enum logic [1:0] {READ, WRITE, INVAL} req_kind_e;
endpackage

// File: rtl/ace_master_port.sv
// ace_master_port: turns cache read/write/invalidate requests into ACE ReadShared, WriteBack and CleanUnique transactions
module ace_master_port
  import ace_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_req,
  input  logic                         write_req,
  input  logic                         invalid_req,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LINE_BEATS*DATA_W-1:0] wb_line,
  output logic                         ace_ready,
  output logic [LINE_BEATS*DATA_W-1:0] fill_line,
  output logic                         resp_shared,
  output logic                         resp_dirty,
  output logic                         resp_err,
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [3:0]                   arsnoop,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [3:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic [ADDR_W-1:0]            awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsnoop,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [DATA_W-1:0]            wdata,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready,
  output logic                         rack,
  output logic                         wack
);
  localparam int LW = LINE_BEATS * DATA_W;
  localparam int CW = $clog2(LINE_BEATS) + 1;
  localparam int BW = CW - 1;
  port_state_e       state_q, state_d;
  req_kind_e         kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     line_q, line_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, shared_q, shared_d, dirty_q, dirty_d;
  logic [7:0]        len;
  logic              beat_last;
  assign len       = kind_q == INVAL ? 8'd0 : 8'(LINE_BEATS - 1);
  assign beat_last = rlast || 8'(cnt_q) == len;
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shared_d = shared_q;
    dirty_d  = dirty_q;
    case (state_q)
      IDLE: if (write_req || read_req || invalid_req) begin
        kind_d   = write_req ? WRITE : read_req ? READ : INVAL;
        state_d  = write_req ? AW_ADDR : AR_ADDR;
        addr_d   = req_addr & ~ADDR_W'(LW / 8 - 1);
        line_d   = wb_line;
        cnt_d    = '0;
        err_d    = 1'b0;
        shared_d = 1'b0;
        dirty_d  = 1'b0;
      end
      AR_ADDR: state_d = arready ? R_DATA : AR_ADDR;
      R_DATA: if (rvalid) begin
        if (kind_q != INVAL) line_d[cnt_q[BW-1:0]*DATA_W +: DATA_W] = rdata;
        cnt_d    = cnt_q + CW'(1);
        err_d    = err_q || rresp[1:0] != RESP_OKAY || rlast != (8'(cnt_q) == len);
        shared_d = beat_last ? rresp[3] : shared_q;
        dirty_d  = beat_last ? rresp[2] : dirty_q;
        state_d  = beat_last ? ACK : R_DATA;
      end
      AW_ADDR: state_d = awready ? W_DATA : AW_ADDR;
      W_DATA: if (wready) begin
        cnt_d   = wlast ? '0 : cnt_q + CW'(1);
        state_d = wlast ? B_RESP : W_DATA;
      end
      B_RESP: if (bvalid) begin
        err_d   = err_q || bresp != RESP_OKAY;
        state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      kind_q   <= READ;
      addr_q   <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      shared_q <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shared_q <= shared_d;
      dirty_q  <= dirty_d;
    end
  assign arvalid     = state_q == AR_ADDR;
  assign araddr      = addr_q;
  assign arlen       = arvalid ? len : '0;
  assign arsnoop     = !arvalid ? '0 : kind_q == INVAL ? ARSNOOP_CLEANUNIQUE : ARSNOOP_READSHARED;
  assign rready      = state_q == R_DATA;
  assign awvalid     = state_q == AW_ADDR;
  assign awaddr      = addr_q;
  assign awlen       = awvalid ? 8'(LINE_BEATS - 1) : '0;
  assign awsnoop     = awvalid ? AWSNOOP_WRITEBACK : '0;
  assign wvalid      = state_q == W_DATA;
  assign wdata       = wvalid ? line_q[cnt_q[BW-1:0]*DATA_W +: DATA_W] : '0;
  assign wlast       = wvalid && cnt_q == CW'(LINE_BEATS - 1);
  assign bready      = state_q == B_RESP;
  assign ace_ready   = state_q == ACK;
  assign rack        = ace_ready && kind_q != WRITE;
  assign wack        = ace_ready && kind_q == WRITE;
  assign fill_line   = line_q;
  assign resp_shared = shared_q;
  assign resp_dirty  = dirty_q;
  assign resp_err    = err_q;
endmodule

// File: tb/tb_ace_master_port.sv
// tb_ace_master_port: table-driven transactions against a scripted interconnect, scoreboard on ace_ready
module tb_ace_master_port;
  logic clk, reset, read_req, write_req, invalid_req;
  logic [31:0] req_addr, araddr, awaddr, rdata, wdata;
  logic [127:0] wb_line, fill_line;
  logic ace_ready, resp_shared, resp_dirty, resp_err;
  logic [7:0] arlen, awlen;
  logic [3:0] arsnoop, rresp;
  logic [2:0] awsnoop;
  logic [1:0] bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, rack, wack;
  ace_master_port dut (
    .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_addr(req_addr), .wb_line(wb_line), .ace_ready(ace_ready), .fill_line(fill_line),
    .resp_shared(resp_shared), .resp_dirty(resp_dirty), .resp_err(resp_err),
    .araddr(araddr), .arlen(arlen), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .rack(rack), .wack(wack)
  );
  typedef struct {
    int kind;
    logic [31:0] addr;
    logic [127:0] data;
    int rlast_beat;
    logic [3:0] rresp_last;
    int err_beat;
    logic [1:0] bresp;
    bit toggle;
    int ar_wait;
    logic [31:0] exp_addr;
    logic [7:0] len;
    logic [3:0] snoop;
    bit chk_fill, shared, dirty, err;
    int lat;
  } vec_t;
  typedef struct {
    bit rack, wack;
    logic [127:0] fill;
    bit chk_fill, shared, dirty, err;
  } exp_t;
  vec_t tbl[7];
  vec_t cfg;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  int cyc, rbeat, wbeat, ar_wait;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (reset && ace_ready) begin
    if (sb.size() == 0) chk("unexpected_ace_ready", ace_ready, 1'b0);
    else begin
      e = sb.pop_front();
      chk("rack", rack, e.rack);
      chk("wack", wack, e.wack);
      if (e.chk_fill) chk("fill_line", fill_line, e.fill);
      chk("resp_shared", resp_shared, e.shared);
      chk("resp_dirty", resp_dirty, e.dirty);
      chk("resp_err", resp_err, e.err);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (arvalid) begin
      chk("araddr", araddr, cfg.exp_addr);
      chk("arlen", arlen, cfg.len);
      chk("arsnoop", arsnoop, cfg.snoop);
    end
    arready = !(arvalid && ar_wait > 0);
    if (!arready) ar_wait--;
    if (rready) begin
      rvalid = 1'b1;
      rdata  = cfg.data[(rbeat % 4) * 32 +: 32];
      rlast  = rbeat == cfg.rlast_beat;
      rresp  = {(rbeat == cfg.rlast_beat || rbeat == int'(cfg.len)) ? cfg.rresp_last[3:2] : 2'b00,
                rbeat == cfg.err_beat ? 2'b10 : 2'b00};
      rbeat++;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 4'b0;
    end
    if (awvalid) begin
      chk("awaddr", awaddr, cfg.exp_addr);
      chk("awlen", awlen, 8'd3);
      chk("awsnoop", awsnoop, 3'b011);
    end
    if (wvalid) begin
      wready = cfg.toggle ? ~wready : 1'b1;
      chk("wdata", wdata, cfg.data[(wbeat % 4) * 32 +: 32]);
      chk("wlast", wlast, wbeat == 3);
      if (wready) wbeat++;
    end
    bvalid = bready;
    bresp  = bready ? cfg.bresp : 2'b00;
  endtask
  task automatic start(input vec_t v);
    cfg = v;
    rbeat = 0;
    wbeat = 0;
    cyc = 0;
    ar_wait = v.ar_wait;
    wready = !v.toggle;
    write_req = v.kind == 1;
    read_req = v.kind == 0;
    invalid_req = v.kind == 2;
    req_addr = v.addr;
    wb_line = v.kind == 1 ? v.data : 128'h0;
    sb.push_back('{v.kind != 1, v.kind == 1, v.data, v.chk_fill, v.shared, v.dirty, v.err});
    tick();
    write_req = 1'b0;
    read_req = 1'b0;
    invalid_req = 1'b0;
  endtask
  task automatic wait_ack();
    while (!ace_ready && cyc < 60) tick();
    chk("ace_ready_within_budget", ace_ready, 1'b1);
  endtask
  initial begin
    vec_t w, r;
    reset = 1'b0;
    {read_req, write_req, invalid_req, rvalid, rlast, bvalid} = '0;
    {arready, awready, wready} = 3'b111;
    req_addr = '0; wb_line = '0; rdata = '0; rresp = '0; bresp = '0;
    tbl[0] = '{0, 32'h1000_0014, 128'h000000A3_000000A2_000000A1_000000A0, 3, 4'b1000, -1, 2'b00, 0, 0,
               32'h1000_0010, 8'd3, 4'b0001, 1, 1, 0, 0, 7};
    tbl[1] = '{1, 32'h2000_003C, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 3, 4'b0000, -1, 2'b00, 1, 0,
               32'h2000_0030, 8'd3, 4'b0000, 0, 0, 0, 0, 11};
    tbl[2] = '{2, 32'h3000_0008, 128'h0, 0, 4'b0000, -1, 2'b00, 0, 0,
               32'h3000_0000, 8'd0, 4'b1011, 0, 0, 0, 0, 4};
    tbl[3] = '{0, 32'h5000_0020, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1, 4'b0000, 0, 2'b00, 0, 0,
               32'h5000_0020, 8'd3, 4'b0001, 0, 0, 0, 1, 5};
    tbl[4] = '{0, 32'h0000_00FF, 128'h44444444_33333333_22222222_11111111, 3, 4'b0100, -1, 2'b00, 0, 2,
               32'h0000_00F0, 8'd3, 4'b0001, 1, 0, 1, 0, 9};
    tbl[5] = '{1, 32'h6000_0010, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 3, 4'b0000, -1, 2'b10, 0, 0,
               32'h6000_0010, 8'd3, 4'b0000, 0, 0, 0, 1, 8};
    tbl[6] = '{0, 32'h7000_0004, 128'h99999999_88888888_77777777_66666666, 9, 4'b1100, -1, 2'b00, 0, 0,
               32'h7000_0000, 8'd3, 4'b0001, 1, 1, 1, 1, 7};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", {ace_ready, arvalid, awvalid, wvalid, rready, bready, rack, wack}, 8'h0);
    chk("reset_fill", fill_line, 128'h0);
    chk("reset_resp", {resp_shared, resp_dirty, resp_err}, 3'b000);
    @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      start(tbl[i]);
      wait_ack();
      chk($sformatf("latency_row%0d", i), cyc + 1, tbl[i].lat);
      tick();
      chk("idle_after_ack", ace_ready, 1'b0);
    end
    w = '{1, 32'h4000_0048, 128'h57570003_57570002_57570001_57570000, 3, 4'b0000, -1, 2'b00, 0, 0,
          32'h4000_0040, 8'd3, 4'b0000, 0, 0, 0, 0, 8};
    r = '{0, 32'h4000_0048, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 3, 4'b0000, -1, 2'b00, 0, 0,
          32'h4000_0040, 8'd3, 4'b0001, 1, 0, 0, 0, 7};
    cfg = w; rbeat = 0; wbeat = 0; cyc = 0; ar_wait = 0; wready = 1'b1;
    write_req = 1'b1; read_req = 1'b1; req_addr = w.addr; wb_line = w.data;
    sb.push_back('{0, 1, w.data, 0, 0, 0, 0});
    sb.push_back('{1, 0, r.data, 1, 0, 0, 0});
    tick();
    chk("write_priority_aw", awvalid, 1'b1);
    write_req = 1'b0;
    wait_ack();
    chk("wb_first_wack", wack, 1'b1);
    chk("no_ar_in_ack", arvalid, 1'b0);
    cfg = r; rbeat = 0; cyc = 0;
    tick();
    chk("no_capture_in_ack", arvalid, 1'b0);
    tick();
    chk("read_after_wb", arvalid, 1'b1);
    read_req = 1'b0;
    wait_ack();
    chk("fill_rack", rack, 1'b1);
    tick();
    w = '{1, 32'h8000_0000, 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000, 3, 4'b0000, -1, 2'b00, 0, 0,
          32'h8000_0000, 8'd3, 4'b0000, 0, 0, 0, 0, 8};
    start(w);
    while (wbeat < 2 && cyc < 30) tick();
    @(posedge clk);
    #1;
    chk("beat2_in_flight", {wvalid, wdata}, {1'b1, 32'hEEEE0002});
    reset = 1'b0;
    #1;
    chk("async_reset_valids", {wvalid, awvalid, ace_ready, arvalid}, 4'b0000);
    sb.delete();
    {rvalid, rlast, bvalid} = '0;
    {arready, awready, wready} = 3'b111;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    chk("post_reset_fill", fill_line, 128'h0);
    chk("post_reset_err", resp_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", {arvalid, awvalid, wvalid, ace_ready}, 4'b0000);
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ace_master_port.md
Name: ace_master_port

Overview:
- Interconnect-facing end of the cache request interface: accepts the level requests read_req / write_req / invalid_req from the cache controller and converts them into ACE-style channel transactions.
- Transaction mapping: ReadShared line fill on AR/R, WriteBack on AW/W/B, CleanUnique on AR/R.
- Returns a single-cycle ace_ready completion pulse together with the fetched line and the coherence response bits.
- Sits between the cache controller and the system interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data beat width
LINE_BEATS, 4, beats per cache line (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
read_req  in  1  line fill request (level, held by requester)
write_req  in  1  dirty line writeback request
invalid_req  in  1  invalidate-others request (may be a 1-cycle pulse)
req_addr  in  ADDR_W  line address, sampled at capture
wb_line  in  LINE_BEATS*DATA_W  writeback data, sampled at capture; beat 0 = LSBs
ace_ready  out  1  1-cycle completion pulse to cache controller
fill_line  out  LINE_BEATS*DATA_W  assembled read line, valid when ace_ready
resp_shared  out  1  RRESP[3] (IsShared) of last read beat
resp_dirty  out  1  RRESP[2] (PassDirty) of last read beat
resp_err  out  1  sticky-per-transaction error, valid when ace_ready
araddr  out  ADDR_W; arlen  out  8; arsnoop  out  4; arvalid  out  1; arready  in  1
rdata  in  DATA_W; rresp  in  4; rlast  in  1; rvalid  in  1; rready  out  1
awaddr  out  ADDR_W; awlen  out  8; awsnoop  out  3; awvalid  out  1; awready  in  1
wdata  out  DATA_W; wlast  out  1; wvalid  out  1; wready  in  1
bresp  in  2; bvalid  in  1; bready  out  1
rack  out  1; wack  out  1

Behaviour:
- Reset is asynchronous: every output goes to 0, FSM to IDLE, beat counter, line buffer and error flag all cleared. Applies mid-transaction; in-flight channel transactions are abandoned.
- FSM states: IDLE, AR_ADDR, R_DATA, AW_ADDR, W_DATA, B_RESP, ACK.
- IDLE:
  - Capture when any request is high.
  - Priority: write_req > read_req > invalid_req.
  - Latch req_addr aligned to line (low log2(LINE_BEATS*DATA_W/8) bits zeroed), latch wb_line, clear resp_err.
  - Requests seen in any other state are ignored; the requester holds them as levels.
- Read:
  - AR_ADDR: arvalid=1, arsnoop=4'b0001, arlen=LINE_BEATS-1. Hold until arready, then R_DATA.
  - Invalidate: same path with arsnoop=4'b1011, arlen=0, no data stored.
- R_DATA:
  - rready=1. On each rvalid beat, store rdata into slot [beat] and increment the counter.
  - Any rresp[1:0]!=0 sets resp_err.
  - Last beat is the one with rlast=1 or counter==arlen, whichever comes first. A mismatch between the two sets resp_err.
  - On the last beat: latch rresp[3:2], go to ACK (read).
- Write:
  - AW_ADDR: awvalid=1, awsnoop=3'b011, awlen=LINE_BEATS-1. On awready go to W_DATA.
  - W_DATA: wvalid=1, wdata=beat[counter], wlast=(counter==LINE_BEATS-1). Counter advances only on wready.
  - After the last beat, go to B_RESP: bready=1. bresp!=0 sets resp_err. On bvalid go to ACK (write).
- ACK:
  - Exactly one cycle: ace_ready=1, plus rack=1 (read/invalidate) or wack=1 (write), then IDLE.
  - fill_line and resp_* hold until the next capture.
- Valid stability: valid and address/data stay stable while waiting for ready. A handshake in the first cycle of a state gives zero wait.
- Latency with all readies high:
  - Read: capture -> ace_ready = 1 + 1 + LINE_BEATS + 1 cycles.
  - Write: 1 + 1 + LINE_BEATS + 1 + 1 cycles.
- Requester timing:
  - ace_ready is never high in IDLE.
  - A request asserted in the ace_ready cycle is not captured; it is captured the following IDLE cycle if still high.
  - This supports a writeback followed by a fill.
- Counter width is log2(LINE_BEATS)+1; no wrap occurs within a transaction.

Decomposition:
- Shared package ace_pkg: ARSNOOP_READSHARED=4'b0001, ARSNOOP_CLEANUNIQUE=4'b1011, AWSNOOP_WRITEBACK=3'b011, RESP_OKAY=2'b00, the port FSM state enum, and the request-kind enum (READ, WRITE, INVAL).
- No sub-module; a line buffer with beat index fits inline.

Test Plan:
- Read fill, all readies high, addr 0x1000_0014, R beats 0xA0..0xA3, rresp=4'b1000 on last beat -> araddr=0x1000_0010, arlen=3, arsnoop=0001; fill_line={A3,A2,A1,A0}; resp_shared=1; ace_ready and rack high together for 1 cycle, 7 cycles after capture.
- Writeback, wb_line={D3,D2,D1,D0}, wready toggling 1/0 -> wdata D0..D3 in order, wlast only with D3; wack and ace_ready for 1 cycle after bvalid.
- invalid_req 1-cycle pulse -> arsnoop=1011, arlen=0, a single R beat accepted, then ace_ready + rack.
- write_req and read_req high together, read_req held after completion -> WriteBack completes first; read captured the cycle after ace_ready; no capture in the ace_ready cycle.
- rlast asserted on beat 1 of 4 and rresp=2'b10 on a beat -> transaction ends, resp_err=1.
- reset low during W_DATA beat 2 -> wvalid/awvalid/ace_ready go to 0 immediately; after reset release, IDLE with no spurious valid.
